// File: rtl/cs_resolve_seq.sv
// Purpose : resolves a carry-save (sum, cout) pair into binary, CHUNK result bits per cycle.
// Latency : out_valid rises NCHUNK cycles after the accepting edge.
// Backpressure: result is held in HOLD until out_ready; in_ready is low whenever the block is busy.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready with sum, cout, approx_en;
//        out_valid/out_ready with result = sext(sum) + (sext(cout) << CARRY_SHIFT); busy in ADD or HOLD.
module cs_resolve_seq #(
    parameter  int SIZE        = 8,
    parameter  int CHUNK       = 4,
    parameter  int CARRY_SHIFT = 1,
    parameter  int APPROX_BITS = 0,
    localparam int IN_W        = SIZE + 3,
    localparam int OUT_W       = SIZE + 4 + CARRY_SHIFT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  sum,
    input  logic [IN_W-1:0]  cout,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             busy
);

    localparam int NCHUNK = (OUT_W + CHUNK - 1) / CHUNK;
    localparam int W2     = NCHUNK * CHUNK;           // result width padded to whole chunks
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SH_W   = $clog2(W2) + 1;
    localparam int EXT_W  = OUT_W - IN_W;

    // Bits that are computed as A|B when approximation is enabled.
    localparam logic [W2-1:0] AMASK = (W2'(1) << APPROX_BITS) - W2'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   a_q, a_d;
    logic [OUT_W-1:0]   b_q, b_d;
    logic               ap_q, ap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [OUT_W-1:0]   result_q, result_d;

    logic [SH_W-1:0]    sh;
    logic [CHUNK-1:0]   a_c, b_c, m_c, r_c;
    logic [CHUNK:0]     add_full;
    logic [W2-1:0]      mask_w;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ap_d     = ap_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;

        // Slice out the current chunk; bits past OUT_W read as zero and are never written back.
        sh     = SH_W'(idx_q) * SH_W'(CHUNK);
        a_c    = CHUNK'(W2'(a_q) >> sh);
        b_c    = CHUNK'(W2'(b_q) >> sh);
        m_c    = ap_q ? CHUNK'(AMASK >> sh) : '0;
        mask_w = W2'({CHUNK{1'b1}}) << sh;

        // Approximate bits are the contiguous low bits, so zeroing them out of the adder
        // also forces the carry into bit APPROX_BITS to zero.
        add_full = {1'b0, a_c & ~m_c} + {1'b0, b_c & ~m_c} + {{CHUNK{1'b0}}, carry_q};
        r_c      = (add_full[CHUNK-1:0] & ~m_c) | ((a_c | b_c) & m_c);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {{EXT_W{sum[IN_W-1]}}, sum};
                    b_d     = {{EXT_W{cout[IN_W-1]}}, cout} << CARRY_SHIFT;
                    ap_d    = approx_en;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                result_d = OUT_W'((W2'(result_q) & ~mask_w) | (W2'(r_c) << sh));
                carry_d  = add_full[CHUNK];
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ap_q     <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ap_q     <= ap_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_cs_resolve_seq.sv
// Purpose : directed and random transactions through cs_resolve_seq with a queue scoreboard.
// Latency : checks that out_valid rises 4 cycles after each accept (SIZE=8, CHUNK=4).
// Backpressure: holds out_ready low in HOLD and checks result/in_ready stability.
module tb_cs_resolve_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] sum;
    logic [10:0] cout;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] result;
    logic        busy;

    int          total;
    int          passed;
    logic [12:0] exp_q[$];

    cs_resolve_seq #(
        .SIZE(8), .CHUNK(4), .CARRY_SHIFT(1), .APPROX_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: sign-extend, weight the carry vector by 2, add; approx low 2 bits are A|B.
    function automatic logic [12:0] model(input logic [10:0] s, input logic [10:0] c, input logic ap);
        logic [12:0] a, b, r;
        a = {{2{s[10]}}, s};
        b = {{2{c[10]}}, c} << 1;
        if (ap) r = (((a >> 2) + (b >> 2)) << 2) | ((a | b) & 13'h0003);
        else    r = a + b;
        return r;
    endfunction

    task automatic run_txn(input string tag, input logic [10:0] s, input logic [10:0] c,
                           input logic ap, input logic [12:0] exp, input int hold);
        int          n;
        logic [12:0] e;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        sum = s; cout = c; approx_en = ap; in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        // Scramble inputs after the accept; they must have no effect.
        in_valid = 1'b0; sum = 11'($urandom); cout = 11'($urandom); approx_en = ~ap;
        chk({tag, "_busy"}, busy, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_latency"}, n, 4);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, exp_q.size(), 1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_result"}, result, e);
        if (hold > 0) begin
            in_valid = 1'b1; sum = 11'h155; cout = 11'h2AA; approx_en = 1'b0;
            repeat (hold) begin @(posedge clk); #1; end
            chk({tag, "_hold_result"}, result, e);
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
            chk({tag, "_hold_busy"}, busy, 1'b1);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        chk({tag, "_no_reload"}, in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, out_valid, 1'b0);
        chk({tag, "_ready_back"}, in_ready, 1'b1);
        chk({tag, "_result_kept"}, result, e);
    endtask

    initial begin
        total = 0; passed = 0;
        rst_n = 1'b0; in_valid = 1'b0; sum = '0; cout = '0; approx_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", result, 13'h0000);
        @(negedge clk); rst_n = 1'b1;

        // out_ready while idle is ignored.
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_out_ready", out_valid, 1'b0);
        out_ready = 1'b0;

        run_txn("t1_exact", 11'd5, 11'd3, 1'b0, 13'h000B, 0);
        run_txn("t2_minus1", 11'h7FF, 11'h000, 1'b0, 13'h1FFF, 0);
        run_txn("t2_neg", 11'h79C, 11'h7EC, 1'b0, 13'h1F74, 0);
        run_txn("t3_backpressure", 11'd42, 11'd7, 1'b0, 13'd56, 5);
        run_txn("t4_approx", 11'd3, 11'd1, 1'b1, 13'd3, 0);
        run_txn("t4_exact", 11'd3, 11'd1, 1'b0, 13'd5, 0);
        run_txn("t5_ripple", 11'h0FF, 11'h001, 1'b0, 13'd257, 0);
        run_txn("max_pos", 11'h3FF, 11'h3FF, 1'b0, 13'h0BFD, 0);
        run_txn("max_neg", 11'h400, 11'h400, 1'b0, 13'h1400, 0);

        // T6: reset during the second ADD cycle.
        while (!in_ready) begin @(posedge clk); #1; end
        sum = 11'h0FF; cout = 11'h001; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_result", result, 13'h0000);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        run_txn("t6_after", 11'h123, 11'h045, 1'b0, model(11'h123, 11'h045, 1'b0), 0);

        for (int i = 0; i < 12; i++) begin
            logic [10:0] rs, rc;
            logic        ra;
            rs = 11'($urandom); rc = 11'($urandom); ra = 1'($urandom);
            run_txn("rand", rs, rc, ra, model(rs, rc, ra), i % 3);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
